// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU widths, alignment constants and the aligner state type.
//   EXP_W        biased exponent width
//   MAN_W        mantissa width including the hidden bit
//   GRS_W        guard/round/sticky width
//   ALIGN_EXT_W  mantissa plus guard and round positions
//   ALIGN_SAT_D  exponent difference at or beyond which every mantissa bit is shifted out
package fpu_pkg;

    localparam int EXP_W       = 8;
    localparam int MAN_W       = 24;
    localparam int GRS_W       = 3;
    localparam int ALIGN_EXT_W = MAN_W + 2;
    localparam int ALIGN_SAT_D = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } align_state_t;

endpackage

// File: rtl/fp_exponent_aligner_if.sv
// fp_exponent_aligner_if: operand/result handshake bundle of the exponent aligner.
//   in_valid/in_ready    operand pair handshake (master drives in_valid)
//   a_e, a_m, b_e, b_m   operand exponents and mantissas (hidden bit at MSB)
//   out_valid/out_ready  aligned result handshake (master drives out_ready)
//   out_e                larger exponent
//   out_big_m            unshifted mantissa of the larger-exponent operand
//   out_small_m          aligned mantissa of the smaller-exponent operand
//   out_grs              {guard, round, sticky}
//   out_swap             1 when B had the larger exponent
// master = operand source / result sink, slave = the aligner.
interface fp_exponent_aligner_if;
    import fpu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] a_e;
    logic [MAN_W-1:0] a_m;
    logic [EXP_W-1:0] b_e;
    logic [MAN_W-1:0] b_m;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] out_e;
    logic [MAN_W-1:0] out_big_m;
    logic [MAN_W-1:0] out_small_m;
    logic [GRS_W-1:0] out_grs;
    logic             out_swap;

    modport master (
        output in_valid, a_e, a_m, b_e, b_m, out_ready,
        input  in_ready, out_valid, out_e, out_big_m, out_small_m, out_grs, out_swap
    );

    modport slave (
        input  in_valid, a_e, a_m, b_e, b_m, out_ready,
        output in_ready, out_valid, out_e, out_big_m, out_small_m, out_grs, out_swap
    );

endinterface

// File: rtl/align_shift_step.sv
// align_shift_step: combinational right shift of the extended mantissa by k (0..STEP),
// reporting whether any 1 bit fell off the bottom.
//   ext_in   extended mantissa {mantissa, guard, round}
//   k        shift amount, 0..STEP
//   ext_out  ext_in >> k
//   dropped  OR of the k bits shifted out
module align_shift_step
    import fpu_pkg::*;
#(
    parameter int STEP = 4,
    localparam int K_W = $clog2(STEP + 1)
) (
    input  logic [ALIGN_EXT_W-1:0] ext_in,
    input  logic [K_W-1:0]         k,
    output logic [ALIGN_EXT_W-1:0] ext_out,
    output logic                   dropped
);

    logic [ALIGN_EXT_W-1:0] drop_mask;

    assign drop_mask = ~({ALIGN_EXT_W{1'b1}} << k);
    assign ext_out   = ext_in >> k;
    assign dropped   = |(ext_in & drop_mask);

endmodule

// File: rtl/fp_exponent_aligner.sv
// fp_exponent_aligner: pre-add alignment; picks the larger exponent and right-shifts the
// other mantissa by the exponent difference, STEP bits per cycle, collecting guard/round/sticky.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fp_exponent_aligner_if.slave (operand and result handshakes)
// Optional build macro ALIGN_FAST_SAT_EN: differences of ALIGN_SAT_D or more finish in one
// cycle instead of iterating; results are bit-identical either way, only latency changes.
module fp_exponent_aligner
    import fpu_pkg::*;
#(
    parameter int STEP = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    fp_exponent_aligner_if.slave bus
);

    localparam int K_W = $clog2(STEP + 1);

    align_state_t           state;
    logic                   swap_q;
    logic [EXP_W-1:0]       e_q;
    logic [EXP_W-1:0]       rem_q;
    logic [MAN_W-1:0]       big_q;
    logic [ALIGN_EXT_W-1:0] ext_q;
    logic                   sticky_q;

    logic                   swap;
    logic [EXP_W-1:0]       d;
    logic [MAN_W-1:0]       small_m;
    logic                   fast_sat;
    logic [K_W-1:0]         k;
    logic [ALIGN_EXT_W-1:0] ext_nx;
    logic                   dropped;

    assign swap    = bus.b_e > bus.a_e;
    assign d       = swap ? bus.b_e - bus.a_e : bus.a_e - bus.b_e;
    assign small_m = swap ? bus.a_m : bus.b_m;

`ifdef ALIGN_FAST_SAT_EN
    // Everything shifts out anyway, so skip straight to the saturated result.
    assign fast_sat = d >= EXP_W'(ALIGN_SAT_D);
`else
    assign fast_sat = 1'b0;
`endif

    assign k = (rem_q < EXP_W'(STEP)) ? K_W'(rem_q) : K_W'(STEP);

    align_shift_step #(.STEP(STEP)) u_step (
        .ext_in  (ext_q),
        .k       (k),
        .ext_out (ext_nx),
        .dropped (dropped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            swap_q   <= 1'b0;
            e_q      <= '0;
            rem_q    <= '0;
            big_q    <= '0;
            ext_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    swap_q <= swap;
                    e_q    <= swap ? bus.b_e : bus.a_e;
                    big_q  <= swap ? bus.b_m : bus.a_m;
                    if (fast_sat) begin
                        rem_q    <= '0;
                        ext_q    <= '0;
                        sticky_q <= |small_m;
                        state    <= DONE;
                    end else begin
                        rem_q    <= d;
                        ext_q    <= {small_m, 2'b00};
                        sticky_q <= 1'b0;
                        state    <= (d == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    ext_q    <= ext_nx;
                    sticky_q <= sticky_q | dropped;
                    rem_q    <= rem_q - EXP_W'(k);
                    if (rem_q == EXP_W'(k)) state <= DONE;
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = state == IDLE;
    assign bus.out_valid   = state == DONE;
    assign bus.out_e       = e_q;
    assign bus.out_big_m   = big_q;
    assign bus.out_small_m = ext_q[ALIGN_EXT_W-1:2];
    assign bus.out_grs     = {ext_q[1], ext_q[0], sticky_q};
    assign bus.out_swap    = swap_q;

endmodule

// File: tb/tb_fp_exponent_aligner.sv
// tb_fp_exponent_aligner: directed and randomized checks of fp_exponent_aligner against an arithmetic reference model.
module tb_fp_exponent_aligner;
    import fpu_pkg::*;

    localparam int STEP = 4;
`ifdef ALIGN_FAST_SAT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_exponent_aligner_if bus();

    fp_exponent_aligner #(.STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0]  x_e;
    logic [23:0] x_big;
    logic [23:0] x_small;
    logic [2:0]  x_grs;
    logic        x_swap;
    int          x_lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Exact alignment by one arithmetic shift of the value (mantissa * 4) by d.
    task automatic model(input logic [7:0] ae, input logic [23:0] am, input logic [7:0] be, input logic [23:0] bm);
        int d;
        logic [63:0] f;
        logic [63:0] q;
        x_swap = be > ae;
        x_e    = x_swap ? be : ae;
        x_big  = x_swap ? bm : am;
        d      = x_swap ? int'(be) - int'(ae) : int'(ae) - int'(be);
        f      = {38'd0, (x_swap ? am : bm), 2'b00};
        if (d >= 26) begin
            x_small = '0;
            x_grs   = {2'b00, f != 0};
        end else begin
            q       = f >> d;
            x_small = q[25:2];
            x_grs   = {q[1], q[0], (q << d) != f};
        end
        x_lat = (d == 0 || (FAST && d >= 26)) ? 1 : 1 + (d + STEP - 1) / STEP;
    endtask

    task automatic issue(input logic [7:0] ae, input logic [23:0] am, input logic [7:0] be, input logic [23:0] bm);
        int w;
        model(ae, am, be, bm);
        bus.a_e = ae;
        bus.a_m = am;
        bus.b_e = be;
        bus.b_m = bm;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(x_lat));
        check({tag, "_e"}, 64'(bus.out_e), 64'(x_e));
        check({tag, "_big"}, 64'(bus.out_big_m), 64'(x_big));
        check({tag, "_small"}, 64'(bus.out_small_m), 64'(x_small));
        check({tag, "_grs"}, 64'(bus.out_grs), 64'(x_grs));
        check({tag, "_swap"}, 64'(bus.out_swap), 64'(x_swap));
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        logic [7:0] ae;
        logic [7:0] be;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_e = '0;
        bus.a_m = '0;
        bus.b_e = '0;
        bus.b_m = '0;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_e", 64'(bus.out_e), 64'd0);
        check("rst_small", 64'(bus.out_small_m), 64'd0);
        check("rst_grs", 64'(bus.out_grs), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'h85, 24'hC00000, 8'h82, 24'h800000);
        collect("basic");
        check("basic_small_lit", 64'(bus.out_small_m), 64'h100000);
        release_out();

        issue(8'h80, 24'h800003, 8'h85, 24'h800001);
        collect("swap");
        check("swap_small_lit", 64'(bus.out_small_m), 64'h040000);
        check("swap_grs_lit", 64'(bus.out_grs), 64'h1);
        release_out();

        issue(8'h7F, 24'h923456, 8'h7F, 24'hABCDEF);
        collect("equal");
        release_out();

        issue(8'h9E, 24'h800000, 8'h80, 24'h800001);
        collect("sat");
        check("sat_grs_lit", 64'(bus.out_grs), 64'h1);
        release_out();

        issue(8'h90, 24'hF0F0F0, 8'h8D, 24'h812345);
        collect("bp1");
        bus.a_e = 8'h40;
        bus.a_m = 24'hC00001;
        bus.b_e = 8'h47;
        bus.b_m = 24'h9ABCDE;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_small", 64'(bus.out_small_m), 64'(x_small));
            check("bp_e", 64'(bus.out_e), 64'(x_e));
        end
        release_out();
        issue(8'h40, 24'hC00001, 8'h47, 24'h9ABCDE);
        collect("bp2");
        release_out();

        issue(8'h94, 24'hFFFFFF, 8'h80, 24'h800000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_small", 64'(bus.out_small_m), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h81, 24'hA5A5A5, 8'h8F, 24'h876543);
        collect("postrst");
        release_out();

        for (int n = 0; n < 40; n++) begin
            ae = 8'($urandom);
            case ($urandom_range(0, 3))
                0: be = ae;
                1: be = ae + 8'($urandom_range(1, 12));
                2: be = ae - 8'($urandom_range(1, 30));
                default: be = 8'($urandom);
            endcase
            issue(ae, {1'b1, 23'($urandom)}, be, 24'($urandom));
            collect("rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_out();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
